bcd_entry_ctrl: RTL
===================

# bcd_entry_ctrl

Clocked controller that sequences three-digit signed BCD temperature entry (tens.units.tenths) from one pushbutton and a 4-bit switch bank, and drives the four seven_seg decoders (HEX0..HEX3).
- Synchronises and debounces the button; accepts one digit per clean press.
- Rejects non-BCD codes.
- Blinks the digit currently being edited and freezes the complete value once entry finishes.
- Runs on CLOCK_50 and sits between the board I/O and the decoders.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles the synchronised key must differ from its debounced level before the level flips (20 ms at 50 MHz); minimum 2.
- BLINK_CYCLES, 12500000, clk cycles per blink half-period of the active digit.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  reset, asynchronous, active-low.
- key_n  in  1  raw pushbutton, active-low, asynchronous, bouncy.
- sw_digit  in  4  digit value to enter.
- sw_sign  in  1  1 = negative.
- digit0  out  4  tenths code to decoder.
- digit1  out  4  units code to decoder.
- digit2  out  4  tens code to decoder.
- sign  out  4  4'hB = minus, 4'hA = blank.
- active_idx  out  2  digit being edited: 0, 1 or 2; 3 = done.
- entry_done  out  1  high while the value is complete and frozen.
- entry_err  out  1  one-cycle pulse on a rejected press.

## Operation
- Decoder codes: 0-9 are digits, 4'hA is OFF (blank), 4'hB is NEGATIVE.
- Input path: key_n passes through a 2-FF synchroniser (s2), then the debouncer.
  - Counter increments each edge where s2 differs from the debounced level `deb`; it clears when they are equal.
  - On the edge where the counter is DEBOUNCE_CYCLES-1 and s2 still differs, `deb` takes s2 and the counter clears.
- press_evt = deb_prev & ~deb, where deb_prev is deb delayed one cycle. It is exactly one cycle per press; holding the key produces no repeats.
- FSM states: T (tenths, idx 0), U (units, idx 1), D (tens, idx 2), DONE (idx 3). Reset enters T.
- press_evt in T, U or D:
  - sw_digit <= 9: latch into that digit's register and advance T->U->D->DONE. The D->DONE transition also latches sw_sign.
  - sw_digit > 9: no latch, no state change, entry_err pulses.
- press_evt in DONE: clear all three digit registers to 0 and return to T. No error pulse.
- Output rules (all outputs are registered and refreshed every cycle):
  - Latched digits show their register value.
  - The active digit shows sw_digit if <= 9, else 4'hA.
  - During the blink-off phase the active digit shows 4'hA.
  - Digits not yet reached show 0.
  - sign follows sw_sign live in T, U and D; in DONE it shows the latched value.
  - entry_done = (state == DONE).
- Blink: counter runs 0..BLINK_CYCLES-1 and toggles the phase on wrap. Phase resets to visible with the counter at 0 on reset and on every accepted press. The phase is ignored in DONE.

## Timing
- While rst is low, all outputs are forced: digit0..2 = 0, sign = 4'hA, active_idx = 0, entry_done = 0, entry_err = 0. FSM = T, debouncer deb = 1, counters = 0, blink phase = visible.
- Reset is honoured mid-debounce or mid-entry: everything clears and partial digits are lost.
- Press latency: if key_n is first sampled low at edge E0, s2 goes low at E1 and deb falls at E1+DEBOUNCE_CYCLES. The digit latch, state change, and any entry_err pulse all occur at E1+DEBOUNCE_CYCLES+1. Registered outputs show the result one edge later.
- Live echo: a sw_digit or sw_sign change appears on its output one edge after it is sampled.
- Glitches: a key_n low pulse, or a release bounce, shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
- **Reset mid-entry:** reset, then clean presses with sw_digit=5,2,1 and sw_sign=1 on the third press, then rst low mid-entry. Expect:
  - after the presses: digit0=5, digit1=2, digit2=1, sign=4'hB, entry_done=1, active_idx=3;
  - after rst low: all outputs return to their reset values asynchronously.
- **Bounce filtering:** key_n low for 3 cycles, high for 2, then low for 10 cycles. Expect exactly one accepted press, with the latch at E1+5 relative to the stable low edge.
- **Invalid digit:** in T with sw_digit=4'hC, press. Expect entry_err high for exactly 1 cycle, state stays T, and digit0 shows 4'hA (blank, invalid echo).
- **Blink:** idle in U with sw_digit=7. Expect digit1 alternating 7 and 4'hA every 8 cycles, starting visible after the accepted press.
- **Restart and latched sign:** in DONE, toggle sw_sign; then press. Expect:
  - sign unchanged while in DONE;
  - after the press: digits = 0, active_idx=0, entry_done=0, no entry_err.
- **Key hold:** hold key_n low for 100 cycles. Expect a single advance only.

Source files
------------

// File: rtl/bcd_entry_ctrl_if.sv
// Board-side bundle for the BCD temperature entry controller: key/switch inputs
// and the four decoder codes plus entry status going out.
interface bcd_entry_ctrl_if;
    logic       key_n;
    logic [3:0] sw_digit;
    logic       sw_sign;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] sign;
    logic [1:0] active_idx;
    logic       entry_done;
    logic       entry_err;

    modport master (
        output key_n, sw_digit, sw_sign,
        input  digit0, digit1, digit2, sign, active_idx, entry_done, entry_err
    );

    modport slave (
        input  key_n, sw_digit, sw_sign,
        output digit0, digit1, digit2, sign, active_idx, entry_done, entry_err
    );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// Three-digit signed BCD entry from one debounced pushbutton and a switch bank,
// driving blanking/minus-aware seven-segment decoder codes.
module bcd_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic            clk,
    input  logic            rst,
    bcd_entry_ctrl_if.slave bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [3:0] CODE_OFF = 4'hA;
    localparam logic [3:0] CODE_NEG = 4'hB;

    typedef enum logic [1:0] {
        ST_T    = 2'd0,
        ST_U    = 2'd1,
        ST_D    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    logic          s1_q, s2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press_evt;

    state_t        state_q, state_d;
    logic [3:0]    dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
    logic          neg_q, neg_d;
    logic          err_d;
    logic          accept;
    logic          digit_ok;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_vis_q, blink_vis_d;

    logic [3:0]    echo, active_code;
    logic [3:0]    digit0_q, digit0_d, digit1_q, digit1_d, digit2_q, digit2_d;
    logic [3:0]    sign_q, sign_d;
    logic [1:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          err_q;

    assign digit_ok  = (bus.sw_digit <= 4'd9);
    assign press_evt = deb_prev_q & ~deb_q;

    // The debounced level only flips after s2 has disagreed with it for a full window.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (s2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = s2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            deb_cnt_q  <= '0;
        end else begin
            s1_q       <= bus.key_n;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        dig2_d  = dig2_q;
        neg_d   = neg_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        if (press_evt) begin
            case (state_q)
                ST_T: begin
                    if (digit_ok) begin
                        dig0_d  = bus.sw_digit;
                        state_d = ST_U;
                        accept  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_U: begin
                    if (digit_ok) begin
                        dig1_d  = bus.sw_digit;
                        state_d = ST_D;
                        accept  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_D: begin
                    if (digit_ok) begin
                        dig2_d  = bus.sw_digit;
                        neg_d   = bus.sw_sign;
                        state_d = ST_DONE;
                        accept  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                    dig2_d  = 4'd0;
                    state_d = ST_T;
                    accept  = 1'b1;
                end
            endcase
        end
    end

    // Every accepted press restarts the blink so the new active digit is seen at once.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_vis_d = blink_vis_q;
        if (accept) begin
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_vis_d = ~blink_vis_q;
        end
    end

    always_comb begin
        echo        = digit_ok ? bus.sw_digit : CODE_OFF;
        active_code = blink_vis_q ? echo : CODE_OFF;
        digit0_d    = 4'd0;
        digit1_d    = 4'd0;
        digit2_d    = 4'd0;
        case (state_q)
            ST_T: begin
                digit0_d = active_code;
            end
            ST_U: begin
                digit0_d = dig0_q;
                digit1_d = active_code;
            end
            ST_D: begin
                digit0_d = dig0_q;
                digit1_d = dig1_q;
                digit2_d = active_code;
            end
            default: begin
                digit0_d = dig0_q;
                digit1_d = dig1_q;
                digit2_d = dig2_q;
            end
        endcase
        if (state_q == ST_DONE) begin
            sign_d = neg_q ? CODE_NEG : CODE_OFF;
        end else begin
            sign_d = bus.sw_sign ? CODE_NEG : CODE_OFF;
        end
        idx_d  = state_q;
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_T;
            dig0_q      <= 4'd0;
            dig1_q      <= 4'd0;
            dig2_q      <= 4'd0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
            digit0_q    <= 4'd0;
            digit1_q    <= 4'd0;
            digit2_q    <= 4'd0;
            sign_q      <= CODE_OFF;
            idx_q       <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dig0_q      <= dig0_d;
            dig1_q      <= dig1_d;
            dig2_q      <= dig2_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
            digit0_q    <= digit0_d;
            digit1_q    <= digit1_d;
            digit2_q    <= digit2_d;
            sign_q      <= sign_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
        end
    end

    assign bus.digit0     = digit0_q;
    assign bus.digit1     = digit1_q;
    assign bus.digit2     = digit2_q;
    assign bus.sign       = sign_q;
    assign bus.active_idx = idx_q;
    assign bus.entry_done = done_q;
    assign bus.entry_err  = err_q;

endmodule
